// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive FIFO placed behind a UART receiver.
// Bytes flagged by uart_ready are stored unless uart_rxerr marks them as bad.
// The consumer side is first-word-fall-through: out_data always shows the
// oldest stored byte while out_valid is high.
//
// Ports
//   clk         : system clock; all state changes on its rising edge
//   reset_n     : asynchronous, active-low reset
//   uart_ready  : one-cycle strobe that marks uart_dout as valid
//   uart_rxerr  : framing error for the byte strobed in the same cycle
//   uart_dout   : received byte
//   out_data    : oldest stored byte (holds its last value when the FIFO is empty)
//   out_valid   : FIFO holds at least one byte
//   out_take    : consumer pop strobe; acts only while out_valid is high
//   count       : occupancy, 0 .. 2**AW
//   almost_full : count >= HiWater
//   overflow    : sticky; a byte was lost because the FIFO was full
//   frame_err   : sticky; a byte was discarded because of uart_rxerr
//   clr_flags   : one-cycle strobe that clears overflow and frame_err
module uart_rx_fifo #(
  parameter int AW      = 4,
  parameter int HiWater = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          uart_ready,
  input  logic          uart_rxerr,
  input  logic [7:0]    uart_dout,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_take,
  output logic [AW:0]   count,
  output logic          almost_full,
  output logic          overflow,
  output logic          frame_err,
  input  logic          clr_flags
);

  localparam int            Depth     = 2 ** AW;
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(Depth);
  localparam logic [AW:0]   HIWATER_C = (AW + 1)'(HiWater);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);

  logic [7:0]    mem_r [Depth];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [7:0]    out_data_r;
  logic          out_valid_r;
  logic          almost_full_r;
  logic          overflow_r;
  logic          frame_err_r;

  logic          push_req_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          bad_s;
  logic [AW-1:0] wr_ptr_s;
  logic [AW-1:0] rd_ptr_s;
  logic [AW:0]   count_s;
  logic [7:0]    head_s;
  logic [7:0]    out_data_s;
  logic          overflow_s;
  logic          frame_err_s;

  // Push/pop qualification and next-state computation for pointers, count, head and flags.
  always_comb begin
    push_req_s  = uart_ready & ~uart_rxerr;
    bad_s       = uart_ready & uart_rxerr;
    full_s      = (count_r == DEPTH_C);
    // out_valid_r mirrors count_r != 0, so this also blocks pops while empty.
    pop_s       = out_take & out_valid_r;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    push_s      = push_req_s & (~full_s | pop_s);
    drop_s      = push_req_s & full_s & ~pop_s;

    wr_ptr_s    = wr_ptr_r;
    rd_ptr_s    = rd_ptr_r;
    count_s     = count_r;
    head_s      = 8'h00;
    out_data_s  = out_data_r;
    overflow_s  = overflow_r;
    frame_err_s = frame_err_r;

    if (push_s) begin
      wr_ptr_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_s = rd_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase

    // The next head is the byte being written right now when the new read
    // pointer lands on the current write slot (empty FIFO, or last byte popped).
    if (push_s && (rd_ptr_s == wr_ptr_r)) begin
      head_s = uart_dout;
    end else begin
      head_s = mem_r[rd_ptr_s];
    end

    if (count_s != CNT_ZERO) begin
      out_data_s = head_s;
    end else begin
      out_data_s = out_data_r;
    end

    // Set events take priority over a coincident clear.
    if (drop_s) begin
      overflow_s = 1'b1;
    end else if (clr_flags) begin
      overflow_s = 1'b0;
    end else begin
      overflow_s = overflow_r;
    end

    if (bad_s) begin
      frame_err_s = 1'b1;
    end else if (clr_flags) begin
      frame_err_s = 1'b0;
    end else begin
      frame_err_s = frame_err_r;
    end
  end

  // Storage array write; contents are never exposed while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= uart_dout;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r      <= PTR_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      count_r       <= CNT_ZERO;
      out_data_r    <= 8'h00;
      out_valid_r   <= 1'b0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      wr_ptr_r      <= wr_ptr_s;
      rd_ptr_r      <= rd_ptr_s;
      count_r       <= count_s;
      out_data_r    <= out_data_s;
      out_valid_r   <= (count_s != CNT_ZERO);
      almost_full_r <= (count_s >= HIWATER_C);
      overflow_r    <= overflow_s;
      frame_err_r   <= frame_err_s;
    end
  end

  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign count       = count_r;
  assign almost_full = almost_full_r;
  assign overflow    = overflow_r;
  assign frame_err   = frame_err_r;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter AW, default 4, meaning log2 of FIFO depth (depth = 2**AW = 16 entries).
REQ-002 The block SHALL have parameter HiWater, default 12, meaning the occupancy at or above which `almost_full` asserts.
REQ-003 The block SHALL have port `clk`, input, 1 bit: single system clock, with all state on its rising edge.
REQ-004 The block SHALL have port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port `uart_ready`, input, 1 bit: one-cycle pulse from the UART receiver marking `uart_dout` valid.
REQ-006 The block SHALL have port `uart_rxerr`, input, 1 bit: framing error for the byte flagged in the same cycle as `uart_ready`.
REQ-007 The block SHALL have port `uart_dout`, input, 8 bits: received byte.
REQ-008 The block SHALL have port `out_data`, output, 8 bits: oldest stored byte, first-word-fall-through.
REQ-009 The block SHALL have port `out_valid`, output, 1 bit: high when the FIFO holds at least one byte.
REQ-010 The block SHALL have port `out_take`, input, 1 bit: consumer pop strobe; one byte is removed per cycle in which `out_take` and `out_valid` are both high.
REQ-011 The block SHALL have port `count`, output, AW+1 bits: current occupancy, 0..2**AW.
REQ-012 The block SHALL have port `almost_full`, output, 1 bit: high when `count` >= HiWater.
REQ-013 The block SHALL have port `overflow`, output, 1 bit: sticky flag for a byte lost because the FIFO was full.
REQ-014 The block SHALL have port `frame_err`, output, 1 bit: sticky flag for a byte discarded due to `uart_rxerr`.
REQ-015 The block SHALL have port `clr_flags`, input, 1 bit: one-cycle pulse that clears `overflow` and `frame_err`.

Function
REQ-016 Push qualification SHALL be: push request = `uart_ready` & ~`uart_rxerr`.
REQ-017 When `uart_ready` & `uart_rxerr`, the byte SHALL be discarded and `frame_err` set on the next edge; storage and `count` stay unchanged.
REQ-018 Pop SHALL occur when `out_take` & `out_valid`; `out_take` while empty SHALL be ignored, with no pointer or count change.
REQ-019 A push request with `count` < 2**AW SHALL write `uart_dout` at the write pointer, advance the write pointer, and increment `count` by 1 on the next edge.
REQ-020 A push request with `count` == 2**AW and no pop in the same cycle SHALL drop the byte and set `overflow`; stored data stays intact.
REQ-021 A push request and a pop in the same cycle while full SHALL both take effect: the byte is accepted, `count` stays at 2**AW, and `overflow` is not set.
REQ-022 A push and a pop in the same cycle at any non-empty occupancy SHALL leave `count` unchanged and advance both pointers.
REQ-023 A push to an empty FIFO SHALL cause `out_valid` = 1 and `out_data` = pushed byte on the cycle after the push edge (1-cycle latency); a same-cycle pop of that byte is impossible, since `out_valid` was 0.
REQ-024 `out_data` SHALL update to the next stored byte on the cycle following a pop edge; when the FIFO becomes empty, `out_data` holds its last value and `out_valid` = 0.
REQ-025 Read and write pointers SHALL be AW bits wide and wrap modulo 2**AW with no gap; `count` is the authoritative full/empty indicator.
REQ-026 `count` SHALL never exceed 2**AW and never underflow below 0.
REQ-027 `almost_full` SHALL be registered-consistent with `count` in the same cycle (a combinational compare of the `count` register is acceptable).
REQ-028 `clr_flags` SHALL clear both sticky flags on the next edge; if a set event and `clr_flags` coincide, the set SHALL win and the flag stays 1.
REQ-029 Sticky flags SHALL remain set until `clr_flags` or reset and SHALL NOT block further pushes.

Reset
REQ-030 Asserting `reset_n` low SHALL immediately, asynchronously, force pointers = 0, `count` = 0, `out_valid` = 0, `out_data` = 8'h00, `almost_full` = 0, `overflow` = 0, `frame_err` = 0.
REQ-031 Reset asserted mid-operation SHALL discard all stored bytes; after release, the first accepted push is the first byte delivered.
REQ-032 Storage array contents need no reset, but SHALL never be visible while `out_valid` = 0, except `out_data` holding its previous value.

Verification
REQ-033 Push 8'hA5 and 8'h3C, then pop twice -> `out_data` shows A5 then 3C, `count` goes 0,1,2,1,0, and `out_valid` drops after the second pop.
REQ-034 Push 17 bytes 0x00..0x10 with no pops -> `count` = 16, `almost_full` = 1 from the 12th push, `overflow` = 1 after byte 0x10, and 16 pops return 0x00..0x0F.
REQ-035 Fill to 16, then push 8'h77 with `out_take` in the same cycle -> `count` stays 16, `overflow` = 0, and the last byte popped is 77.
REQ-036 Pulse `uart_ready` with `uart_rxerr` = 1 and data 8'hFF -> `frame_err` = 1, `count` = 0; then pulse `clr_flags` coincident with another rxerr -> `frame_err` stays 1, and the next lone `clr_flags` -> 0.
REQ-037 Run 40 push/pop cycles to wrap the pointers twice, then assert `reset_n` low with `count` = 5 -> all outputs are 0 immediately; push 8'h12 after release -> `out_data` = 12, `count` = 1.
